// File: rtl/switch_debouncer_if.sv
// Switch debouncer bus: raw switch levels and enable in, debounced levels and
// change strobe/mask out.
interface switch_debouncer_if;
    logic       en;
    logic       sw_a;
    logic       sw_b;
    logic       sw_c;
    logic       a;
    logic       b;
    logic       c;
    logic       chg;
    logic [2:0] chg_mask;

    modport master (
        output en, sw_a, sw_b, sw_c,
        input  a, b, c, chg, chg_mask
    );

    modport slave (
        input  en, sw_a, sw_b, sw_c,
        output a, b, c, chg, chg_mask
    );
endinterface

// File: rtl/switch_debouncer.sv
// Three-channel switch debouncer: 2-flop synchronizer, persistence counter and
// stable level per channel, plus a registered change strobe with channel mask.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_debouncer_if.slave   bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] raw;
    logic [2:0] s_vec;
    logic [2:0] mask_next;
    logic       chg_reg;
    logic [2:0] chg_mask_reg;

    assign raw = {bus.sw_c, bus.sw_b, bus.sw_a};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
            logic             sync1_reg;
            logic             sync2_reg;
            logic             s_reg;
            logic             s_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             accept;

            // Synchronizer runs regardless of en so the first enabled edge
            // already sees a settled level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            always_comb begin
                cnt_next = '0;
                s_next   = s_reg;
                accept   = 1'b0;
                if (bus.en && (sync2_reg != s_reg)) begin
                    if (cnt_reg >= LAST_CNT) begin
                        s_next = sync2_reg;
                        accept = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    s_reg   <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    s_reg   <= s_next;
                end
            end

            assign s_vec[gi]     = s_reg;
            assign mask_next[gi] = accept;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_reg      <= 1'b0;
            chg_mask_reg <= 3'b000;
        end else begin
            chg_reg      <= |mask_next;
            chg_mask_reg <= mask_next;
        end
    end

    assign bus.a        = s_vec[0];
    assign bus.b        = s_vec[1];
    assign bus.c        = s_vec[2];
    assign bus.chg      = chg_reg;
    assign bus.chg_mask = chg_mask_reg;
endmodule
